signal_sampler: RTL and testbench

SIGNAL_SAMPLER -- requirements
Module: signal_sampler

---
 rtl/signal_pkg.sv | 13 +
 rtl/sample_tick_gen.sv | 23 ++
 rtl/signal_sampler.sv | 123 ++++++++++++
 tb/tb_signal_sampler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_pkg.sv
// Shared types and default sizing for the signal sampler.
package signal_pkg;
   localparam int ADC_BITS_DEF = 12;
   localparam int N_ANALOG_DEF = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ACCUM,
      S_DONE
   } state_t;
endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..rate_div and ticks on the wrap cycle.
module sample_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [DIV_W-1:0] rate_div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt;
   logic             wrap;

   // >= so that shrinking rate_div below the live count wraps immediately
   assign wrap = enable && (cnt >= rate_div);
   assign tick = wrap && !reset;

   always_ff @(posedge clk) begin
      if (reset || !enable) cnt <= '0;
      else if (wrap)        cnt <= '0;
      else                  cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/signal_sampler.sv
// Multi-channel ADC + digital bus sampler with power-of-two window averaging.
module signal_sampler
   import signal_pkg::*;
#(
   parameter int N_ANALOG     = N_ANALOG_DEF,
   parameter int N_DIGITAL    = 8,
   parameter int ADC_BITS     = ADC_BITS_DEF,
   parameter int DIV_W        = 16,
   parameter int MAX_AVG_LOG2 = 4,
   localparam int CH_W  = (N_ANALOG > 1) ? $clog2(N_ANALOG) : 1,
   localparam int AVG_W = (MAX_AVG_LOG2 > 0) ? $clog2(MAX_AVG_LOG2 + 1) : 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic [DIV_W-1:0]                   rate_div,
   input  logic [AVG_W-1:0]                   avg_log2,
   input  logic [N_DIGITAL-1:0]               digital,
   output logic                               adc_start,
   output logic [CH_W-1:0]                    adc_channel,
   input  logic [ADC_BITS-1:0]                adc_data,
   input  logic                               adc_valid,
   output logic [N_ANALOG-1:0][ADC_BITS-1:0]  analog_out,
   output logic [N_DIGITAL-1:0]               digital_out,
   output logic                               ready,
   output logic                               overrun,
   input  logic                               overrun_clr
);
   localparam int ACC_W = ADC_BITS + MAX_AVG_LOG2;
   localparam int RND_W = MAX_AVG_LOG2 + 1;
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_ANALOG - 1);
   localparam logic [AVG_W-1:0] MAX_LAT = AVG_W'(MAX_AVG_LOG2);

   state_t                         state, state_n;
   logic                           tick;
   logic [CH_W-1:0]                idx;
   logic [N_ANALOG-1:0][ACC_W-1:0] acc;
   logic [RND_W-1:0]               rounds, rounds_inc;
   logic [AVG_W-1:0]               avg_lat;
   logic [N_DIGITAL-1:0]           dig_hold;
   logic                           win_done;

   sample_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .rate_div (rate_div),
      .tick     (tick)
   );

   assign rounds_inc  = rounds + 1'b1;
   assign win_done    = (rounds_inc == (RND_W'(1) << avg_lat));
   assign adc_channel = idx;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      adc_start = 1'b0;
      ready     = 1'b0;
      unique case (state)
         S_IDLE:  if (tick) state_n = S_REQ;
         S_REQ: begin
            adc_start = 1'b1;
            state_n   = S_WAIT;
         end
         S_WAIT:  if (adc_valid) state_n = (idx == LAST_CH) ? S_ACCUM : S_REQ;
         S_ACCUM: state_n = win_done ? S_DONE : S_IDLE;
         S_DONE: begin
            ready   = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx         <= '0;
         acc         <= '0;
         rounds      <= '0;
         avg_lat     <= '0;
         dig_hold    <= '0;
         analog_out  <= '0;
         digital_out <= '0;
         overrun     <= 1'b0;
      end else begin
         // a dropped tick outranks a simultaneous clear
         if (tick && state != S_IDLE) overrun <= 1'b1;
         else if (overrun_clr)        overrun <= 1'b0;

         case (state)
            S_IDLE: if (tick) begin
               dig_hold <= digital;
               idx      <= '0;
               if (rounds == '0)
                  avg_lat <= (avg_log2 > MAX_LAT) ? MAX_LAT : avg_log2;
            end
            S_WAIT: if (adc_valid) begin
               acc[idx] <= acc[idx] + ACC_W'(adc_data);
               if (idx != LAST_CH) idx <= idx + 1'b1;
            end
            S_ACCUM: begin
               rounds <= rounds_inc;
               // publish here so outputs are already stable when ready pulses in DONE
               if (win_done) begin
                  for (int i = 0; i < N_ANALOG; i++)
                     analog_out[i] <= ADC_BITS'(acc[i] >> avg_lat);
                  digital_out <= dig_hold;
               end
            end
            S_DONE: begin
               acc    <= '0;
               rounds <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_signal_sampler.sv
// Directed bench for signal_sampler with a behavioural ADC and a result scoreboard.
module tb_signal_sampler;
   logic              clk = 1'b0;
   logic              reset, enable, overrun_clr;
   logic [15:0]       rate_div;
   logic [2:0]        avg_log2;
   logic [7:0]        digital;
   logic              adc_start;
   logic [0:0]        adc_channel;
   logic [11:0]       adc_data;
   logic              adc_valid;
   logic [1:0][11:0]  analog_out;
   logic [7:0]        digital_out;
   logic              ready, overrun;

   signal_sampler dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .rate_div    (rate_div),
      .avg_log2    (avg_log2),
      .digital     (digital),
      .adc_start   (adc_start),
      .adc_channel (adc_channel),
      .adc_data    (adc_data),
      .adc_valid   (adc_valid),
      .analog_out  (analog_out),
      .digital_out (digital_out),
      .ready       (ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0][11:0] an;
      logic [7:0]       dg;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0, errs = 0;
   int          cyc = 0;
   int          starts = 0, ch0_starts = 0;
   int          last_valid_cyc = 0, prev_ready_cyc = -1;
   bit          lat_chk = 0, per_chk = 0;
   int          adc_lat = 2;
   int          ch0_inc = 0;
   logic [11:0] ch0_val = '0, ch1_val = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [11:0] a1, input logic [11:0] a0, input logic [7:0] d);
      exp_t e;
      e.an = {a1, a0};
      e.dg = d;
      sbq.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ready(input int n, input int maxc, input string tag);
      int got = 0;
      int c = 0;
      while (got < n && c < maxc) begin
         @(negedge clk);
         c++;
         if (ready) got++;
      end
      chk(tag, got, n);
   endtask

   task automatic wait_start(input int maxc, input string tag);
      int c = 0;
      while (!adc_start && c < maxc) begin
         @(negedge clk);
         c++;
      end
      chk(tag, adc_start, 1);
   endtask

   // ADC model: answers each request adc_lat cycles after the start cycle
   initial begin
      logic ch;
      adc_valid = 1'b0;
      adc_data  = '0;
      forever begin
         @(negedge clk);
         if (adc_start) begin
            ch = adc_channel[0];
            repeat (adc_lat) @(posedge clk);
            #1;
            adc_valid = 1'b1;
            adc_data  = ch ? ch1_val : ch0_val;
            if (!ch) ch0_val = ch0_val + 12'(ch0_inc);
            @(posedge clk);
            #1 adc_valid = 1'b0;
         end
      end
   end

   // result monitor / scoreboard consumer
   always @(negedge clk) begin
      exp_t e;
      if (adc_start) begin
         starts++;
         if (adc_channel == 1'b0) ch0_starts++;
      end
      if (adc_valid) last_valid_cyc = cyc;
      if (ready) begin
         chk("spurious_ready", sbq.size() != 0, 1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("analog_out", analog_out, e.an);
            chk("digital_out", digital_out, e.dg);
         end
         if (lat_chk) chk("ready_latency", cyc - last_valid_cyc, 2);
         if (per_chk && prev_ready_cyc >= 0) chk("ready_period", cyc - prev_ready_cyc, 10);
         prev_ready_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt_nz;
      reset = 1'b1; enable = 1'b0; overrun_clr = 1'b0;
      rate_div = 16'd9; avg_log2 = 3'd0; digital = 8'h00;
      step(3);
      chk("rst_analog", analog_out, 0);
      chk("rst_digital", digital_out, 0);
      chk("rst_ready", ready, 0);
      chk("rst_adc_start", adc_start, 0);
      chk("rst_adc_channel", adc_channel, 0);
      chk("rst_overrun", overrun, 0);

      // enable low: no requests, divider parked at zero
      reset = 1'b0; digital = 8'hFF; starts = 0; cnt_nz = 0;
      repeat (50) begin
         @(negedge clk);
         if (dut.u_tick.cnt != 16'd0) cnt_nz++;
      end
      chk("idle_starts", starts, 0);
      chk("idle_div_nonzero", cnt_nz, 0);

      // plain sampling, period and latency
      ch0_val = 12'h123; ch1_val = 12'h456; ch0_inc = 0; adc_lat = 2; digital = 8'hA5;
      repeat (3) push_exp(12'h456, 12'h123, 8'hA5);
      lat_chk = 1; per_chk = 1; prev_ready_cyc = -1;
      enable = 1'b1;
      wait_ready(3, 60, "plain_readies");
      enable = 1'b0;
      step(1);
      lat_chk = 0; per_chk = 0;
      chk("plain_no_overrun", overrun, 0);
      digital = 8'h00;
      step(20);
      chk("hold_analog", analog_out, {12'h456, 12'h123});
      chk("hold_digital", digital_out, 8'hA5);

      // 4-round average; mid-window avg_log2 change must be ignored
      digital = 8'h3C; ch0_val = 12'd10; ch0_inc = 1; ch1_val = 12'd100; avg_log2 = 3'd2;
      push_exp(12'd100, 12'd11, 8'h3C);
      ch0_starts = 0;
      enable = 1'b1;
      step(15);
      avg_log2 = 3'd0;
      wait_ready(1, 80, "avg4_ready");
      enable = 1'b0;
      chk("avg4_ch0_conversions", ch0_starts, 4);

      // full-scale 16-round average
      avg_log2 = 3'd4; ch0_val = 12'hFFF; ch0_inc = 0; ch1_val = 12'hFFF; digital = 8'h81;
      push_exp(12'hFFF, 12'hFFF, 8'h81);
      enable = 1'b1;
      wait_ready(1, 200, "avg16_ready");
      enable = 1'b0;

      // avg_log2 above maximum saturates to 16 rounds: ch0 0..15 -> 7
      avg_log2 = 3'd7; ch0_val = 12'd0; ch0_inc = 1; ch1_val = 12'h800; digital = 8'h42;
      push_exp(12'h800, 12'd7, 8'h42);
      enable = 1'b1;
      wait_ready(1, 200, "sat_ready");
      enable = 1'b0;

      // fast ticks with slow ADC: overrun, dropped ticks issue no requests
      step(2);
      rate_div = 16'd1; adc_lat = 5; avg_log2 = 3'd0;
      ch0_val = 12'h111; ch0_inc = 0; ch1_val = 12'h222; digital = 8'h5A;
      push_exp(12'h222, 12'h111, 8'h5A);
      push_exp(12'h222, 12'h111, 8'h5A);
      starts = 0;
      enable = 1'b1;
      wait_ready(2, 100, "ovr_readies");
      enable = 1'b0;
      chk("ovr_set", overrun, 1);
      chk("ovr_starts", starts, 4);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      step(1);
      chk("ovr_cleared", overrun, 0);

      // tick every cycle with clear held: set must win
      rate_div = 16'd0; overrun_clr = 1'b1;
      push_exp(12'h222, 12'h111, 8'h5A);
      enable = 1'b1;
      wait_ready(1, 60, "clr_tick_ready");
      enable = 1'b0;
      chk("clr_vs_tick", overrun, 1);
      step(2);
      chk("clr_idle", overrun, 0);
      overrun_clr = 1'b0;

      // reset during WAIT, stale adc_valid afterwards
      rate_div = 16'd9; adc_lat = 4; ch0_val = 12'h321; ch1_val = 12'h654; digital = 8'h99;
      enable = 1'b1;
      wait_start(40, "rstw_start_seen");
      step(2);
      reset = 1'b1; enable = 1'b0;
      step(1);
      reset = 1'b0;
      step(4);
      chk("rstw_analog", analog_out, 0);
      chk("rstw_digital", digital_out, 0);
      chk("rstw_overrun", overrun, 0);
      chk("rstw_acc", dut.acc, 0);
      push_exp(12'h654, 12'h321, 8'h99);
      enable = 1'b1;
      wait_start(40, "rstw_restart_seen");
      chk("rstw_restart_ch", adc_channel, 0);
      wait_ready(1, 60, "rstw_ready");
      enable = 1'b0;

      step(5);
      chk("sb_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end
endmodule
